ffs_rr_arbiter_m: RTL

FFS_RR_ARBITER_M -- requirements
Module: ffs_rr_arbiter_m

---
 rtl/ffs_rr_arbiter_m.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ffs_rr_arbiter_m.sv
// ffs_rr_arbiter_m: round-robin arbiter with a registered one-hot grant.
// A grant is held while its requester keeps req high. When the holder drops
// req, the next winner is granted on the same edge, with no idle cycle.
// Winner selection: lowest set index above the pointer first, then wrap to index 0.
//
// Optional feature: define FFS_ARB_TIMEOUT_EN to add a hold counter. It forces a
// handover after MAX_HOLD consecutive grant cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[N]     request vector, held high for a whole transaction
//   gnt[N]     registered grant, one-hot or zero
//   gnt_valid  registered, high when gnt is non-zero
//   gnt_idx    registered binary index of the grant, 0 when idle
module ffs_rr_arbiter_m #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IW      = $clog2((N > 2) ? N : 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    // Reject illegal configurations at elaboration
    if (N < 1 || N > 64 || MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_param_err
        $error("ffs_rr_arbiter_m: parameter out of range");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;

`ifdef FFS_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hcnt_q, hcnt_d;
`endif

    // Lowest set bit index of v (0 when v is empty)
    function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Round-robin pick: indices above ptr first, else the full vector
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] ptr);
        logic [N-1:0] hi;
        for (int i = 0; i < int'(N); i++) begin
            hi[i] = v[i] && (i > int'(ptr));
        end
        return (|hi) ? lowest(hi) : lowest(v);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] oh;
        for (int i = 0; i < int'(N); i++) begin
            oh[i] = (idx == IW'(i));
        end
        return oh;
    endfunction

    logic [IW-1:0] win_c;
    logic          holder_req_c;
    logic          load_c;
    logic [IW-1:0] load_idx_c;

    // gnt_q masks the holder, which avoids indexing req by gnt_idx
    assign win_c        = rr_pick(req, ptr_q);
    assign holder_req_c = |(req & gnt_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        load_c     = 1'b0;
        load_idx_c = win_c;
`ifdef FFS_ARB_TIMEOUT_EN
        hcnt_d     = hcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    load_c = 1'b1;
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                end
            end
            S_BUSY: begin
                if (holder_req_c) begin
`ifdef FFS_ARB_TIMEOUT_EN
                    if (hcnt_q == HW'(MAX_HOLD - 1)) begin
                        // Forced handover; re-grant the holder if nobody else waits
                        load_c = 1'b1;
                        if (|(req & ~gnt_q)) begin
                            load_idx_c = rr_pick(req & ~gnt_q, ptr_q);
                        end else begin
                            load_idx_c = idx_q;
                        end
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
`endif
                end else if (|req) begin
                    load_c = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_c) begin
            state_d = S_BUSY;
            gnt_d   = onehot(load_idx_c);
            valid_d = 1'b1;
            idx_d   = load_idx_c;
            ptr_d   = load_idx_c;
`ifdef FFS_ARB_TIMEOUT_EN
            hcnt_d  = '0;
`endif
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= IW'(N - 1);
`ifdef FFS_ARB_TIMEOUT_EN
            hcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef FFS_ARB_TIMEOUT_EN
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_idx   = idx_q;

endmodule
